// File: rtl/stream_serializer.sv
// Width-down stream serializer: emits the kept lanes of a wide word one per narrow beat.
// Optional macro STREAM_SERIALIZER_MSB_FIRST_EN selects descending lane order.
module stream_serializer #(
    parameter int unsigned NumLanes  = 4,
    parameter int unsigned LaneWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumLanes*LaneWidth-1:0] in_data_i,
    input  logic [NumLanes-1:0]           in_keep_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [LaneWidth-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam int unsigned IdxWidth = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    localparam logic [0:0] StIdle      = 1'b0;
    localparam logic [0:0] StSerialize = 1'b1;

    logic [0:0]                    r_state;
    logic [NumLanes*LaneWidth-1:0] r_word;
    logic [NumLanes-1:0]           r_mask;

    logic [IdxWidth-1:0]  w_idx;
    logic [NumLanes-1:0]  w_idx_onehot;
    logic [LaneWidth-1:0] w_lane_data;
    logic                 w_last;
    logic                 w_out_valid;
    logic                 w_out_hs;
    logic                 w_in_ready;
    logic                 w_in_hs;

    // Priority scan: the last match written wins, so scan direction picks lowest or highest bit.
    always_comb begin
        w_idx = '0;
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        for (int i = 0; i < int'(NumLanes); i++) begin
            if (r_mask[i]) w_idx = IdxWidth'(i);
        end
`else
        for (int i = int'(NumLanes) - 1; i >= 0; i--) begin
            if (r_mask[i]) w_idx = IdxWidth'(i);
        end
`endif
    end

    always_comb begin
        w_idx_onehot = '0;
        w_idx_onehot[w_idx] = 1'b1;
        w_lane_data = '0;
        for (int i = 0; i < int'(NumLanes); i++) begin
            if (w_idx == IdxWidth'(i)) w_lane_data = r_word[i*int'(LaneWidth) +: LaneWidth];
        end
    end

    assign w_last      = (r_mask != '0) && ((r_mask & (r_mask - NumLanes'(1))) == '0);
    assign w_out_valid = (r_state == StSerialize);
    assign w_out_hs    = w_out_valid && out_ready_i;
    assign w_in_ready  = (r_state == StIdle) || (w_out_hs && w_last);
    assign w_in_hs     = in_valid_i && w_in_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_word  <= '0;
            r_mask  <= '0;
        end else if (w_in_hs) begin
            // An all-zero keep word is consumed without producing any beat.
            if (in_keep_i != '0) begin
                r_state <= StSerialize;
                r_word  <= in_data_i;
                r_mask  <= in_keep_i;
            end else begin
                r_state <= StIdle;
                r_mask  <= '0;
            end
        end else if (w_out_hs) begin
            if (w_last) begin
                r_state <= StIdle;
                r_mask  <= '0;
            end else begin
                r_mask <= r_mask & ~w_idx_onehot;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_last_o  = w_out_valid && w_last;
    assign out_data_o  = w_out_valid ? w_lane_data : '0;

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: directed scenarios plus a random scoreboard run.
// Lane order expectations follow STREAM_SERIALIZER_MSB_FIRST_EN when it is defined.
module tb_stream_serializer;

    localparam int NL = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic [3:0]    in_keep = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          out_valid;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    stream_serializer #(.NumLanes(NL), .LaneWidth(LW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_keep_i  (in_keep),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: list kept lanes in emission order; the final listed lane is the last beat.
    function automatic void model_push(logic [31:0] d, logic [3:0] k);
        int order[$];
        beat_t b;
        for (int i = 0; i < NL; i++) begin
            if (k[i]) begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
                order.push_front(i);
`else
                order.push_back(i);
`endif
            end
        end
        for (int j = 0; j < order.size(); j++) begin
            b.d = d[order[j]*LW +: LW];
            b.l = (j == order.size() - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_last !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_outs: got last=%b data=%h expected 0/00", out_last, out_data);
        end
        tick;
    endtask

`ifndef STREAM_SERIALIZER_MSB_FIRST_EN
    task automatic test_full_word;
        logic [7:0] exp_d[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        in_data = 32'hDDCCBBAA; in_keep = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_accept_ready: got %b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[b] || out_last !== (b == 3)) begin
                errors++;
                $display("FAIL full_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         b, out_valid, out_data, out_last, exp_d[b], (b == 3));
            end
            checks++;
            if (in_ready !== (b == 3)) begin
                errors++; $display("FAIL full_ready%0d: got %b expected %b", b, in_ready, (b == 3));
            end
            tick;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL full_done: got valid=%b expected 0", out_valid);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        in_data = 32'h44332211; in_keep = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_data = 32'h88776655;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h11 * (b + 1)) ||
                out_last !== (b == 3 || b == 7)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", b,
                         out_valid, out_data, out_last, 8'(8'h11 * (b + 1)), (b == 3 || b == 7));
            end
            tick;
            if (b == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_done: got valid=%b expected 0", out_valid);
        end
        tick;
    endtask

    task automatic test_sparse;
        in_data = 32'hDDCCBBAA; in_keep = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hBB || out_last !== 1'b0) begin
            errors++; $display("FAIL sparse_bb: got v=%b d=%h l=%b expected 1/BB/0",
                               out_valid, out_data, out_last);
        end
        tick;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hDD || out_last !== 1'b1) begin
            errors++; $display("FAIL sparse_dd: got v=%b d=%h l=%b expected 1/DD/1",
                               out_valid, out_data, out_last);
        end
        tick;
        in_data = 32'h12345678; in_keep = 4'b0000; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL empty_ready: got %b expected 1", in_ready);
        end
        tick;
        in_data = 32'h000000EE; in_keep = 4'b0001;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL empty_nobeat: got v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hEE || out_last !== 1'b1) begin
            errors++; $display("FAIL single_ee: got v=%b d=%h l=%b expected 1/EE/1",
                               out_valid, out_data, out_last);
        end
        tick;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: got valid=%b expected 0", out_valid);
        end
        tick;
    endtask

    task automatic test_mid_reset;
        in_data = 32'hDDCCBBAA; in_keep = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hBB) begin
            errors++; $display("FAIL midrst_bb: got v=%b d=%h expected 1/BB", out_valid, out_data);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL midrst_quiet%0d: got v=%b rdy=%b expected 0/1",
                                   c, out_valid, in_ready);
            end
            tick;
        end
        in_data = 32'h04030201; in_keep = 4'hF; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(b + 1) || out_last !== (b == 3)) begin
                errors++; $display("FAIL midrst_beat%0d: got v=%b d=%h l=%b expected 1/%h/%b",
                                   b, out_valid, out_data, out_last, 8'(b + 1), (b == 3));
            end
            tick;
        end
    endtask
`else
    task automatic test_msb_first;
        logic [3:0] keeps[2] = '{4'b1111, 4'b0101};
        logic [7:0] exp_d[2][4] = '{'{8'hDD, 8'hCC, 8'hBB, 8'hAA}, '{8'hCC, 8'hAA, 8'h00, 8'h00}};
        int         nbeats[2] = '{4, 2};
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_data = 32'hDDCCBBAA; in_keep = keeps[w]; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            for (int b = 0; b < nbeats[w]; b++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d[w][b] ||
                    out_last !== (b == nbeats[w] - 1)) begin
                    errors++;
                    $display("FAIL msb_w%0d_beat%0d: got v=%b d=%h l=%b expected 1/%h/%b", w, b,
                             out_valid, out_data, out_last, exp_d[w][b], (b == nbeats[w] - 1));
                end
                tick;
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL msb_w%0d_done: got valid=%b expected 0", w, out_valid);
            end
            tick;
        end
    endtask
`endif

    task automatic test_backpressure;
        int         accepted = 0;
        int         cycles = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_d = '0;
        logic       prev_l = 1'b0;
        beat_t      e;
        exp_q.delete();
        in_valid = 1'b0; out_ready = 1'b0;
        while ((accepted < 200 || exp_q.size() != 0) && cycles < 5000) begin
            in_valid  = (accepted < 200) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_keep   = 4'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    errors++; $display("FAIL stall_hold: got v=%b d=%h l=%b expected 1/%h/%b",
                                       out_valid, out_data, out_last, prev_d, prev_l);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got beat d=%h expected no beat", out_data);
                end else begin
                    e = exp_q[0];
                    if (out_data !== e.d || out_last !== e.l) begin
                        errors++; $display("FAIL bp_beat: got d=%h l=%b expected d=%h l=%b",
                                           out_data, out_last, e.d, e.l);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (in_valid && in_ready === 1'b1) begin
                model_push(in_data, in_keep);
                accepted++;
            end
            tick;
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 200 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_complete: got accepted=%0d pending=%0d expected 200/0",
                               accepted, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        test_msb_first();
`else
        test_full_word();
        test_back_to_back();
        test_sparse();
        test_mid_reset();
`endif
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
